// File: rtl/spi_pkg.sv
// Shared defaults and FSM state type for the SPI byte receiver.
package spi_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin with registered rise/fall strobes.
// o_level is the synchronized value delayed to line up with o_rise/o_fall.
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_sync;

    assign w_sync = r_chain[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_pin};
            r_prev  <= w_sync;
            r_rise  <= w_sync & ~r_prev;
            r_fall  <= ~w_sync & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receiver: oversampled pins, MSB-first deserializer, word strobe and frame error.
// Optional build macro SPI_RX_ECHO_EN adds a MISO echo of the previously received word.
module spi_byte_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] spi_out,
    output logic              spi_done,
    output logic              spi_busy,
    output logic              frame_err
);

    localparam int                CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);
    localparam int                FL_W    = $clog2(SYNC_STAGES + 3);
    localparam logic [FL_W-1:0]   FLUSH_N = FL_W'(SYNC_STAGES + 2);

    logic                   w_sck_lvl;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_lvl;
    logic                   w_cs_rise;
    logic                   w_cs_fall;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_mosi_d;

    logic                   r_sck_rise_p0;
    logic                   r_sck_fall_p0;
    logic                   r_cs_rise_p0;
    logic                   r_cs_fall_p0;
    logic                   r_cs_lvl_p0;
    logic                   r_mosi_p0;

    logic [FL_W-1:0]        r_flush;
    logic                   r_armed;
    logic                   r_busy;

    spi_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_out;
    logic                   r_done;
    logic                   r_err;
    logic [DATA_W-1:0]      w_shift_next;
    logic                   w_frame_start;

    spi_pin_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (sck),
        .o_level (w_sck_lvl),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_pin_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (cs_n),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // MOSI gets the plain chain plus one flop so it lines up with the edge strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= '0;
            r_mosi_d    <= 1'b0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    // stage p0: registered events feeding the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_rise_p0 <= 1'b0;
            r_sck_fall_p0 <= 1'b0;
            r_cs_rise_p0  <= 1'b0;
            r_cs_fall_p0  <= 1'b0;
            r_cs_lvl_p0   <= 1'b1;
            r_mosi_p0     <= 1'b0;
        end else begin
            r_sck_rise_p0 <= w_sck_rise;
            r_sck_fall_p0 <= w_sck_fall;
            r_cs_rise_p0  <= w_cs_rise;
            r_cs_fall_p0  <= w_cs_fall;
            r_cs_lvl_p0   <= w_cs_lvl;
            r_mosi_p0     <= r_mosi_d;
        end
    end

    // After reset the chains hold fake values; only accept a new frame once cs_n is really seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush <= '0;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (r_flush != FLUSH_N) begin
                r_flush <= r_flush + FL_W'(1);
            end
            if (r_flush == FLUSH_N && r_cs_lvl_p0) begin
                r_armed <= 1'b1;
            end
            r_busy <= ~w_cs_lvl;
        end
    end

    assign w_shift_next  = {r_shift[DATA_W-2:0], r_mosi_p0};
    assign w_frame_start = (r_state == IDLE) && r_cs_fall_p0 && r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_frame_start) begin
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // cs_n release beats a coincident sck rise; that bit is dropped
                    if (r_cs_rise_p0) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        if (r_cnt != '0) begin
                            r_err <= 1'b1;
                        end
                    end else if (r_sck_rise_p0) begin
                        r_shift <= w_shift_next;
                        if (r_cnt == LAST) begin
                            r_out  <= w_shift_next;
                            r_done <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_RX_ECHO_EN
    logic [DATA_W-1:0] r_tx;
    logic              r_miso;
    logic              w_unused;

    // r_tx holds the bits still to be shifted out after the one currently on MISO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= '0;
            r_miso <= 1'b0;
        end else if (w_frame_start) begin
            r_miso <= r_out[DATA_W-1];
            r_tx   <= {r_out[DATA_W-2:0], 1'b0};
        end else if (r_state == ACTIVE) begin
            if (r_done) begin
                r_tx <= r_out;
            end else if (r_sck_fall_p0) begin
                r_miso <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign miso     = r_miso;
    assign w_unused = w_sck_lvl;
`else
    logic w_unused;

    assign miso     = 1'b0;
    assign w_unused = w_sck_lvl ^ r_sck_fall_p0;
`endif

    assign spi_out   = r_out;
    assign spi_done  = r_done;
    assign spi_busy  = r_busy;
    assign frame_err = r_err;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: SPI master model driving sck/cs_n/mosi, inline checks per scenario.
module tb_spi_byte_rx;

    localparam int DATA_W = 8;
    localparam int HALF   = 8;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              sck  = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic [DATA_W-1:0] spi_out;
    logic              spi_done;
    logic              spi_busy;
    logic              frame_err;

    int                checks = 0;
    int                errors = 0;
    int                n_done = 0;
    int                n_err  = 0;
    int                n_both = 0;
    logic [7:0]        last_val = 8'h00;
    logic [7:0]        miso_cap = 8'h00;

    always #5 clk = ~clk;

    spi_byte_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .spi_out   (spi_out),
        .spi_done  (spi_done),
        .spi_busy  (spi_busy),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (spi_done) begin
            n_done   <= n_done + 1;
            last_val <= spi_out;
        end
        if (frame_err) n_err <= n_err + 1;
        if (spi_done && frame_err) n_both <= n_both + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_clk(HALF);
        miso_cap = {miso_cap[6:0], miso};
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic frame_open;
        cs_n = 1'b0;
        wait_clk(10);
    endtask

    task automatic frame_close;
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(3);
        checks++; if (spi_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %0h expected 0", spi_out); end
        checks++; if (spi_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", spi_done); end
        checks++; if (spi_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", spi_busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        rst = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_single;
        int d0, e0, lat;
        logic [7:0] v;
        v  = 8'hA5;
        d0 = n_done;
        e0 = n_err;
        frame_open();
        checks++; if (spi_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", spi_busy); end
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        mosi = v[0];
        wait_clk(HALF);
        sck = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!spi_done && lat < 20);
        checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d negedges expected 5", lat); end
        wait_clk(4);
        sck = 1'b0;
        frame_close();
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", n_done - d0); end
        checks++; if (last_val !== 8'hA5) begin errors++; $display("FAIL single_strobe_val: got %0h expected a5", last_val); end
        checks++; if (spi_out !== 8'hA5) begin errors++; $display("FAIL single_out: got %0h expected a5", spi_out); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_partial;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        frame_open();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        frame_close();
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL partial_err_cnt: got %0d expected 1", n_err - e0); end
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL partial_done_cnt: got %0d expected 0", n_done - d0); end
        checks++; if (spi_out !== 8'hA5) begin errors++; $display("FAIL partial_out: got %0h expected a5", spi_out); end
    endtask

    task automatic test_back_to_back;
        int d0, e0;
        logic [7:0] vec [3];
        vec = '{8'h3C, 8'hFF, 8'h00};
        d0  = n_done;
        e0  = n_err;
        frame_open();
        for (int k = 0; k < 3; k++) begin
            send_byte(vec[k]);
            checks++; if (n_done - d0 !== k + 1) begin errors++; $display("FAIL b2b_done_cnt[%0d]: got %0d expected %0d", k, n_done - d0, k + 1); end
            checks++; if (last_val !== vec[k]) begin errors++; $display("FAIL b2b_val[%0d]: got %0h expected %0h", k, last_val, vec[k]); end
        end
        frame_close();
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_idle_sck;
        int d0;
        logic busy_seen;
        d0 = n_done;
        busy_seen = 1'b0;
        cs_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            sck = 1'b1;
            wait_clk(HALF);
            if (spi_busy !== 1'b0) busy_seen = 1'b1;
            sck = 1'b0;
            wait_clk(HALF);
        end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_seen); end
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL idle_done_cnt: got %0d expected 0", n_done - d0); end
    endtask

    task automatic test_reset_midframe;
        int d0, e0;
        frame_open();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        rst = 1'b1;
        wait_clk(3);
        checks++; if (spi_out !== 8'h00) begin errors++; $display("FAIL midrst_out: got %0h expected 0", spi_out); end
        rst = 1'b0;
        wait_clk(10);
        d0 = n_done;
        e0 = n_err;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL midrst_stale_done: got %0d expected 0", n_done - d0); end
        cs_n = 1'b1;
        wait_clk(12);
        frame_open();
        send_byte(8'h42);
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL midrst_done_cnt: got %0d expected 1", n_done - d0); end
        checks++; if (spi_out !== 8'h42) begin errors++; $display("FAIL midrst_out_42: got %0h expected 42", spi_out); end
        frame_close();
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL midrst_err: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_echo;
        logic [7:0] exp_miso;
`ifdef SPI_RX_ECHO_EN
        exp_miso = 8'h5A;
`else
        exp_miso = 8'h00;
`endif
        frame_open();
        send_byte(8'h5A);
        frame_close();
        frame_open();
        miso_cap = 8'h00;
        send_byte(8'hC3);
        frame_close();
        checks++; if (miso_cap !== exp_miso) begin errors++; $display("FAIL echo_miso: got %0h expected %0h", miso_cap, exp_miso); end
        checks++; if (spi_out !== 8'hC3) begin errors++; $display("FAIL echo_out: got %0h expected c3", spi_out); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_back_to_back();
        test_idle_sck();
        test_reset_midframe();
        test_echo();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL done_err_overlap: got %0d expected 0", n_both); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
